float_normalizer: RTL
=====================

// Module: float_normalizer
// PURPOSE
//  Iterative left-normalizer feeding float_rounder. Takes a wide unnormalized mantissa with
//  sign and exponent and shifts out leading zeros, one log-step per cycle. Emits the N-bit
//  rounder operand plus {guard, sticky}. Valid/ready handshake on both sides.
// PARAMETERS
//  N     24    rounder operand width (out_a)
//  M     48    input mantissa width; M >= N+2
//  E     10    signed exponent width
//  EMIN  -126  minimum normal exponent (subnormal floor)
//  K     $clog2(M), localparam: number of shift steps
// PORTS
//  clock          in   1            system clock
//  reset_n        in   1            async active-low reset
//  in_valid       in   1            input operand valid
//  in_ready       out  1            block can accept (state==IDLE)
//  in_sign        in   1            operand sign
//  in_exp         in   E            signed exponent of in_mant[M-1]
//  in_mant        in   M            unnormalized mantissa
//  in_round_mode  in   round_mode_t sideband, carried to output unchanged
//  out_valid      out  1            result valid (state==DONE)
//  out_ready      in   1            downstream accepts
//  out_sign       out  1            registered in_sign
//  out_exp        out  E            adjusted exponent
//  out_a          out  N            mant[M-1 -: N] after shifting
//  out_sticky     out  2            {guard=mant[M-N-1], sticky=|mant[M-N-2:0]}
//  out_round_mode out  round_mode_t registered sideband
//  out_zero       out  1            in_mant was all zero
// BEHAVIOUR
//  Clock is clock; reset is reset_n, asynchronous and active-low.
//  - Reset: state IDLE, out_valid=0, all datapath regs 0, out_round_mode=RNE.
//    in_ready=1 once in IDLE.
//  - FSM IDLE->SHIFT on in_valid&&in_ready. Operands and round_mode are registered, step=K-1.
//  - SHIFT: each edge performs step s, then decrements s. After s=0 go to DONE.
//  - DONE: hold all outputs stable while out_ready=0. On out_ready go to IDLE.
//  - Latency: out_valid high exactly K edges after the accepting edge.
//  - Throughput: 1 op per K+2 cycles. in_ready=0 in SHIFT/DONE; no bypass.
//  - Step s: let lz_ok = mant[M-1 -: 2**s]==0 and bud_ok = (exp - 2**s) >= EMIN.
//    If lz_ok && bud_ok: mant <<= 2**s (zero fill), exp -= 2**s. Otherwise hold.
//    Greedy result is an exact shift of min(lzc, exp-EMIN).
//  - Exponent arithmetic in E+1 bits signed; no wrap.
//    If in_exp < EMIN on entry, no shift occurs.
//  - Zero: out_zero=1, out_a=0, out_sticky=0, out_exp=EMIN. Fixed latency still applies.
//  - Shift steps 2**s >= M treat the whole window as the test range.
//  - Reset mid-SHIFT/DONE: immediate abort to IDLE, out_valid=0, no result emitted.
// CONFIGURATION
//  FLOAT_NORM_SUBNORM_EN defined: bud_ok applied as above. Results at EMIN may be
//    unnormalized (subnormal) for float_rounder.
//  Undefined: bud_ok forced 1. Shift is full lzc, exp may drop below EMIN.
//    Zero still reports out_exp=EMIN.
// STRUCTURE
//  float_pkg: existing round_mode_t; add norm_state_t {IDLE,SHIFT,DONE}.
//  Single module, no sub-module. Step logic is one combinational block indexed by step.
// TESTING (N=4, M=8, E=6, EMIN=-6, K=3, macro defined unless noted)
//  1. mant=8'b0001_0110, exp=0 -> a=4'b1011, sticky=2'b00, exp=-3; out_valid 3 edges after accept.
//  2. mant=8'b0000_0011, exp=-4 -> shift 2: a=4'b0000, sticky=2'b11, exp=-6.
//     Macro undefined: a=4'b1100, sticky=2'b00, exp=-10.
//  3. mant=0, exp=5, sign=1 -> out_zero=1, a=0, sticky=0, exp=-6, out_sign=1.
//  4. mant=8'b1010_0101, exp=2, round_mode=RMM -> no shift: a=4'b1010, sticky=2'b01, exp=2,
//     round_mode=RMM.
//  5. Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
//     Then out_ready=1 -> IDLE next edge, in_ready=1.
//  6. reset_n low during SHIFT step 1 -> out_valid=0 immediately, IDLE.
//     Next op (case 1) completes correctly.
//  Scoreboard: reference model chains this block with float_rounder for all 256 mant,
//  exp in [-8,7], every non-DYN mode.

Source files
------------

// File: rtl/float_normalizer_pkg.sv
// ============================================================================
// float_normalizer_pkg : shared types for the float normalizer / rounder path
// Revision: 1.0
// ============================================================================
`default_nettype none

package float_normalizer_pkg;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4,
        DYN = 3'd7
    } round_mode_t;

    typedef enum logic [1:0] {
        NORM_IDLE  = 2'd0,
        NORM_SHIFT = 2'd1,
        NORM_DONE  = 2'd2
    } norm_state_t;

endpackage

`default_nettype wire

// File: rtl/float_normalizer_if.sv
// ============================================================================
// float_normalizer_if : operand-in / result-out handshake bundle
// Revision: 1.0
// ============================================================================
`default_nettype none

interface float_normalizer_if
    import float_normalizer_pkg::*;
#(
    parameter int N = 24,
    parameter int M = 48,
    parameter int E = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              in_sign;
    logic [E-1:0]      in_exp;
    logic [M-1:0]      in_mant;
    round_mode_t       in_round_mode;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [E-1:0]      out_exp;
    logic [N-1:0]      out_a;
    logic [1:0]        out_sticky;
    round_mode_t       out_round_mode;
    logic              out_zero;

    // Normalizer side
    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_round_mode, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_a, out_sticky,
               out_round_mode, out_zero
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_round_mode, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_a, out_sticky,
               out_round_mode, out_zero
    );
endinterface

`default_nettype wire

// File: rtl/float_normalizer.sv
// ============================================================================
// float_normalizer : iterative log-step left normalizer feeding float_rounder
// Optional macro FLOAT_NORM_SUBNORM_EN clamps the shift at the EMIN floor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module float_normalizer
    import float_normalizer_pkg::*;
#(
    parameter int N    = 24,
    parameter int M    = 48,
    parameter int E    = 10,
    parameter int EMIN = -126
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    float_normalizer_if.slave     bus
);
    localparam int K  = $clog2(M);
    localparam int SW = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic signed [E:0] EMIN_X = EMIN[E:0];

    logic [1:0]           r_state;
    logic [SW-1:0]        r_step;
    logic [M-1:0]         r_mant;
    logic signed [E:0]    r_exp;
    logic                 r_sign;
    logic                 r_zero;
    round_mode_t          r_round_mode;

    logic [K:0]           w_sh;
    logic signed [E:0]    w_sh_e;
    logic signed [E:0]    w_exp_dec;
    logic [M-1:0]         w_top_mask;
    logic [M-1:0]         w_mant_shl;
    logic                 w_lz_ok;
    logic                 w_bud_ok;

    // Shift distance 2**step; a distance >= M makes the mask cover the whole window.
    always_comb begin
        w_sh       = (K+1)'(1) << r_step;
        w_sh_e     = signed'((E+1)'(w_sh));
        w_exp_dec  = r_exp - w_sh_e;
        w_top_mask = ~({M{1'b1}} >> w_sh);
        w_mant_shl = r_mant << w_sh;
        w_lz_ok    = ((r_mant & w_top_mask) == '0);
`ifdef FLOAT_NORM_SUBNORM_EN
        w_bud_ok   = (w_exp_dec >= EMIN_X);
`else
        w_bud_ok   = 1'b1;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_step       <= '0;
            r_mant       <= '0;
            r_exp        <= '0;
            r_sign       <= 1'b0;
            r_zero       <= 1'b0;
            r_round_mode <= RNE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_mant       <= bus.in_mant;
                        r_exp        <= {bus.in_exp[E-1], bus.in_exp};
                        r_sign       <= bus.in_sign;
                        r_zero       <= (bus.in_mant == '0);
                        r_round_mode <= bus.in_round_mode;
                        r_step       <= SW'(K - 1);
                        r_state      <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_lz_ok && w_bud_ok) begin
                        r_mant <= w_mant_shl;
                        r_exp  <= w_exp_dec;
                    end
                    if (r_step == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_step <= r_step - SW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready       = (r_state == ST_IDLE);
    assign bus.out_valid      = (r_state == ST_DONE);
    assign bus.out_sign       = r_sign;
    assign bus.out_a          = r_mant[M-1 -: N];
    assign bus.out_sticky     = {r_mant[M-N-1], |r_mant[M-N-2:0]};
    // An all-zero mantissa reports the floor exponent regardless of how far it slid.
    assign bus.out_exp        = r_zero ? EMIN_X[E-1:0] : r_exp[E-1:0];
    assign bus.out_round_mode = r_round_mode;
    assign bus.out_zero       = r_zero;

endmodule

`default_nettype wire
